// File: rtl/aclk_pkg.sv
// -----------------------------------------------------------------------------
// aclk_pkg
// Shared types and helpers for the multi-alarm BCD real-time clock.
//   bcd_hm_t      : HH:MM in BCD (h1 is 2 bits, the other digits 4 bits)
//   bcd_hms_t     : HH:MM:SS in BCD
//   alarm_state_e : per-channel alarm state
//   hm_valid()    : checks that a loaded HH:MM is a legal BCD time (<= 23:59)
//   hm_add_min()  : HH:MM + n minutes, wrapping at 24h (snooze deadline)
// -----------------------------------------------------------------------------
package aclk_pkg;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        bcd_hm_t    hm;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_hms_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_e;

    localparam int HM_W = $bits(bcd_hm_t);

    function automatic logic hm_valid(input bcd_hm_t t);
        return (t.h1 <= 2'd2) && (t.h0 <= 4'd9) &&
               (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
               ((t.h1 != 2'd2) || (t.h0 <= 4'd3));
    endfunction

    // Only called with a constant minute count, so the divides fold into
    // small constant-divisor logic.
    function automatic bcd_hm_t hm_add_min(input bcd_hm_t t, input int unsigned mins);
        int unsigned h;
        int unsigned m;
        bcd_hm_t     r;
        m = 32'(t.m1) * 32'd10 + 32'(t.m0) + mins;
        h = 32'(t.h1) * 32'd10 + 32'(t.h0);
        h = (h + m / 32'd60) % 32'd24;
        m = m % 32'd60;
        r.h1 = 2'(h / 32'd10);
        r.h0 = 4'(h % 32'd10);
        r.m1 = 4'(m / 32'd10);
        r.m0 = 4'(m % 32'd10);
        return r;
    endfunction

endpackage

// File: rtl/aclk_alarm_chan.sv
// -----------------------------------------------------------------------------
// aclk_alarm_chan
// One alarm channel: alarm HH:MM register, ringing FSM and (optionally) the
// snooze deadline.
// Optional feature macro: ACLK_SNOOZE_EN (adds SNOOZED state + deadline reg).
// Ports:
//   clk, reset_n : clock, async active-low reset
//   wr, wr_hm    : write alarm register (already validated by the top)
//   al_on, stop  : arm enable / stop for this channel
//   snooze       : snooze request (unused without ACLK_SNOOZE_EN)
//   min_edge     : this edge advances the time onto a new minute (SS=00)
//   next_hm      : HH:MM the time becomes on this edge
//   cur_hm       : HH:MM currently displayed
//   alarm        : registered ringing flag
// -----------------------------------------------------------------------------
module aclk_alarm_chan
    import aclk_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr,
    input  logic [HM_W-1:0] wr_hm,
    input  logic            al_on,
    input  logic            stop,
    input  logic            snooze,
    input  logic            min_edge,
    input  logic [HM_W-1:0] next_hm,
    input  logic [HM_W-1:0] cur_hm,
    output logic            alarm
);

    bcd_hm_t      alarm_hm;
    alarm_state_e state;
    logic         hit;

    // Match only on a tick-driven rollover into alarm_hm:00, never on a load.
    assign hit = min_edge && (bcd_hm_t'(next_hm) == alarm_hm) && al_on;

`ifdef ACLK_SNOOZE_EN
    bcd_hm_t deadline;
    logic    wake;

    assign wake = min_edge && (bcd_hm_t'(next_hm) == deadline);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            alarm_hm <= '0;
            deadline <= '0;
        end else begin
            if (wr)
                alarm_hm <= bcd_hm_t'(wr_hm);
            case (state)
                IDLE: begin
                    if (hit && !stop) begin
                        state <= RINGING;
                        alarm <= 1'b1;
                    end
                end
                RINGING: begin
                    if (stop || !al_on) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else if (snooze) begin
                        state    <= SNOOZED;
                        alarm    <= 1'b0;
                        deadline <= hm_add_min(bcd_hm_t'(cur_hm), SNOOZE_MIN);
                    end
                end
                SNOOZED: begin
                    if (stop || !al_on) begin
                        state <= IDLE;
                    end else if (wake) begin
                        state <= RINGING;
                        alarm <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{snooze, cur_hm};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            alarm_hm <= '0;
        end else begin
            if (wr)
                alarm_hm <= bcd_hm_t'(wr_hm);
            case (state)
                IDLE: begin
                    if (hit && !stop) begin
                        state <= RINGING;
                        alarm <= 1'b1;
                    end
                end
                RINGING: begin
                    if (stop || !al_on) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: rtl/aclk_rtc_multi_alarm.sv
// -----------------------------------------------------------------------------
// aclk_rtc_multi_alarm
// BCD HH:MM:SS real-time clock with a CLK_DIV prescaler and N_ALARMS
// independently armed alarm channels.
// Optional feature macro: ACLK_SNOOZE_EN (per-channel snooze).
// Ports:
//   clk, reset_n                 : system clock, async active-low reset
//   H_in1/H_in0/M_in1/M_in0      : BCD HH:MM for LD_time / LD_alarm
//   LD_time, LD_alarm, alarm_sel : load clock / load alarm[alarm_sel]
//   AL_ON, STOP_al, snooze       : per-channel arm / stop / snooze
//   H_out*, M_out*, S_out*       : registered current time
//   Alarm                        : per-channel ringing flag
//   ld_err                       : one-cycle pulse on a rejected load
// -----------------------------------------------------------------------------
module aclk_rtc_multi_alarm
    import aclk_pkg::*;
#(
    parameter  int CLK_DIV    = 10,
    parameter  int N_ALARMS   = 2,
    parameter  int SNOOZE_MIN = 5,
    localparam int SEL_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [SEL_W-1:0]    alarm_sel,
    input  logic [N_ALARMS-1:0] AL_ON,
    input  logic [N_ALARMS-1:0] STOP_al,
    input  logic [N_ALARMS-1:0] snooze,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0,
    output logic [N_ALARMS-1:0] Alarm,
    output logic                ld_err
);

    localparam int             PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(CLK_DIV - 1);
    localparam logic [SEL_W:0] NSEL = (SEL_W + 1)'(N_ALARMS);

    logic [PW-1:0] presc;
    bcd_hms_t      cur;
    bcd_hms_t      nxt;
    bcd_hm_t       in_hm;
    logic          in_ok;
    logic          sel_ok;
    logic          time_ok;
    logic          tick;
    logic          adv;
    logic          min_edge;

    assign in_hm   = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0};
    assign in_ok   = hm_valid(in_hm);
    assign sel_ok  = {1'b0, alarm_sel} < NSEL;
    assign time_ok = LD_time && in_ok;
    assign tick    = (presc == PMAX);
    // A valid time load wins over a coincident tick.
    assign adv      = tick && !time_ok;
    assign min_edge = adv && (cur.s1 == 4'd5) && (cur.s0 == 4'd9);

    // Time + 1 s with BCD carries; loads are validated, so digits stay BCD.
    always_comb begin
        nxt = cur;
        if (cur.s0 != 4'd9) begin
            nxt.s0 = cur.s0 + 4'd1;
        end else begin
            nxt.s0 = 4'd0;
            if (cur.s1 != 4'd5) begin
                nxt.s1 = cur.s1 + 4'd1;
            end else begin
                nxt.s1 = 4'd0;
                if (cur.hm.m0 != 4'd9) begin
                    nxt.hm.m0 = cur.hm.m0 + 4'd1;
                end else begin
                    nxt.hm.m0 = 4'd0;
                    if (cur.hm.m1 != 4'd5) begin
                        nxt.hm.m1 = cur.hm.m1 + 4'd1;
                    end else begin
                        nxt.hm.m1 = 4'd0;
                        if (cur.hm.h1 == 2'd2 && cur.hm.h0 == 4'd3) begin
                            nxt.hm.h1 = 2'd0;
                            nxt.hm.h0 = 4'd0;
                        end else if (cur.hm.h0 == 4'd9) begin
                            nxt.hm.h0 = 4'd0;
                            nxt.hm.h1 = cur.hm.h1 + 2'd1;
                        end else begin
                            nxt.hm.h0 = cur.hm.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            cur    <= '0;
            ld_err <= 1'b0;
        end else begin
            ld_err <= (LD_time && !in_ok) || (LD_alarm && (!in_ok || !sel_ok));
            if (time_ok) begin
                cur.hm <= in_hm;
                cur.s1 <= 4'd0;
                cur.s0 <= 4'd0;
                presc  <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick)
                    cur <= nxt;
            end
        end
    end

    assign H_out1 = cur.hm.h1;
    assign H_out0 = cur.hm.h0;
    assign M_out1 = cur.hm.m1;
    assign M_out0 = cur.hm.m0;
    assign S_out1 = cur.s1;
    assign S_out0 = cur.s0;

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
        logic wr;
        assign wr = LD_alarm && in_ok && sel_ok && (alarm_sel == SEL_W'(i));

        aclk_alarm_chan #(
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr),
            .wr_hm    (in_hm),
            .al_on    (AL_ON[i]),
            .stop     (STOP_al[i]),
            .snooze   (snooze[i]),
            .min_edge (min_edge),
            .next_hm  (nxt.hm),
            .cur_hm   (cur.hm),
            .alarm    (Alarm[i])
        );
    end

endmodule

// File: tb/tb_aclk_rtc_multi_alarm.sv
// -----------------------------------------------------------------------------
// tb_aclk_rtc_multi_alarm
// Scoreboard bench for aclk_rtc_multi_alarm (CLK_DIV=10, N_ALARMS=2).
// Expected values are queued with the cycle they must appear at; a negedge
// monitor pops and compares them. Snooze scenarios run when ACLK_SNOOZE_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_aclk_rtc_multi_alarm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [0:0] alarm_sel;
    logic [1:0] AL_ON, STOP_al, snooze;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
    logic [1:0] Alarm;
    logic       ld_err;

    aclk_rtc_multi_alarm #(.CLK_DIV(10), .N_ALARMS(2), .SNOOZE_MIN(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel),
        .AL_ON(AL_ON), .STOP_al(STOP_al), .snooze(snooze),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0), .Alarm(Alarm), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;   // 0 time, 1 Alarm, 2 ld_err
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;

    // cyc = rising edges since reset release
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tm(input int h, input int m, input int s);
        return {10'd0, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] obs(input int s);
        case (s)
            0:       return {10'd0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
            1:       return {30'd0, Alarm};
            default: return {31'd0, ld_err};
        endcase
    endfunction

    // sorted insert so pushes need not be issued in cycle order
    task automatic push(input int c, input int s, input logic [31:0] v, input string t);
        exp_t e;
        int   k;
        e.cyc = c; e.sel = s; e.exp = v; e.tag = t;
        k = q.size();
        while (k > 0 && q[k-1].cyc > c) k--;
        q.insert(k, e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) chk({mon_e.tag, "_missed"}, 32'(cyc), 32'(mon_e.cyc));
            else                 chk(mon_e.tag, obs(mon_e.sel), mon_e.exp);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_raw(input bit t, input bit a, input int sel,
                            input int h1, input int h0, input int m1, input int m0);
        H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
        alarm_sel = 1'(sel);
        LD_time = t; LD_alarm = a;
        @(posedge clk); #2;
        LD_time = 1'b0; LD_alarm = 1'b0;
    endtask

    task automatic load_hm(input bit t, input bit a, input int sel, input int h, input int m);
        load_raw(t, a, sel, h / 10, h % 10, m / 10, m % 10);
    endtask

    task automatic pulse_stop(input logic [1:0] v);
        STOP_al = v;
        @(posedge clk); #2;
        STOP_al = 2'b00;
    endtask

    task automatic pulse_snooze(input logic [1:0] v);
        snooze = v;
        @(posedge clk); #2;
        snooze = 2'b00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        H_in1 = '0; H_in0 = '0; M_in1 = '0; M_in0 = '0;
        LD_time = 1'b0; LD_alarm = 1'b0; alarm_sel = '0;
        AL_ON = '0; STOP_al = '0; snooze = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_time",   obs(0), 32'd0);
        chk("rst_alarm",  obs(1), 32'd0);
        chk("rst_ld_err", obs(2), 32'd0);
        reset_n = 1'b1;

        // free run from reset
        push(9,   0, tm(0, 0, 0), "before_first_tick");
        push(10,  0, tm(0, 0, 1), "first_tick_edge10");
        push(600, 0, tm(0, 1, 0), "one_minute");
        push(600, 1, 32'd0,       "no_alarm_run");

        // midnight rollover with channel 0 at 00:00
        goto(600);
        AL_ON = 2'b01;
        push(1200, 0, tm(23, 59, 59), "pre_midnight");
        push(1200, 1, 32'd0,          "pre_midnight_al");
        push(1201, 0, tm(0, 0, 0),    "midnight");
        push(1201, 1, 32'd1,          "midnight_ring0");
        push(1205, 1, 32'd1,          "ring0_hold");
        push(1206, 1, 32'd0,          "ring0_stopped");
        load_hm(1, 0, 0, 23, 59);
        goto(1205);
        pulse_stop(2'b01);

        // channel 1 at 07:30
        goto(1210);
        AL_ON = 2'b10;
        load_hm(0, 1, 1, 7, 30);
        load_hm(1, 0, 0, 7, 29);
        push(1811, 0, tm(7, 29, 59), "pre_0730");
        push(1811, 1, 32'd0,         "pre_0730_al");
        push(1812, 0, tm(7, 30, 0),  "at_0730");
        push(1812, 1, 32'd2,         "ring1_0730");
        push(1814, 1, 32'd2,         "ld_alarm_while_ringing");
        push(1815, 1, 32'd2,         "ring1_hold");
        push(1816, 1, 32'd0,         "ring1_stopped");
        goto(1813);
        load_hm(0, 1, 1, 8, 0);
        goto(1815);
        pulse_stop(2'b10);

        // rejected loads
        push(1821, 2, 32'd1,        "lderr_hour24");
        push(1821, 0, tm(7, 30, 0), "time_kept_h24");
        push(1822, 2, 32'd0,        "lderr_clear1");
        push(1822, 0, tm(7, 30, 1), "time_runs_h24");
        goto(1820);
        load_raw(1, 0, 0, 2, 4, 0, 0);
        push(1824, 2, 32'd1,        "lderr_min60");
        push(1824, 0, tm(7, 30, 1), "time_kept_m60");
        push(1825, 2, 32'd0,        "lderr_clear2");
        goto(1823);
        load_raw(1, 0, 0, 1, 2, 6, 0);
        push(1827, 2, 32'd1,        "lderr_alarm_digit");
        push(1828, 2, 32'd0,        "lderr_clear3");
        goto(1826);
        load_raw(0, 1, 1, 0, 10, 0, 0);

        // LD_time in the tick cycle
        push(1841, 0, tm(7, 30, 2), "before_ld_tick");
        push(1842, 0, tm(7, 59, 0), "ld_on_tick");
        push(1851, 0, tm(7, 59, 0), "hold_after_ld");
        push(1852, 0, tm(7, 59, 1), "first_inc_after_ld");
        goto(1841);
        load_hm(1, 0, 0, 7, 59);
        // channel 1 still holds 08:00 despite the rejected write
        push(2441, 1, 32'd0, "pre_0800");
        push(2442, 1, 32'd2, "ring1_0800_intact");
        push(2446, 1, 32'd0, "ring1_stopped2");
        goto(2445);
        pulse_stop(2'b10);

        // STOP coincident with match
        AL_ON = 2'b11;
        load_hm(0, 1, 0, 8, 1);
        push(3042, 0, tm(8, 1, 0), "at_0801");
        push(3042, 1, 32'd0,       "stop_beats_match");
        push(3043, 1, 32'd0,       "stop_beats_match2");
        goto(3041);
        pulse_stop(2'b01);

        // AL_ON drop ends ringing
        goto(3045);
        load_hm(0, 1, 0, 8, 2);
        push(3642, 0, tm(8, 2, 0), "at_0802");
        push(3642, 1, 32'd1,       "ring0_0802");
        push(3644, 1, 32'd1,       "ring0_hold2");
        push(3645, 1, 32'd0,       "al_on_drop");
`ifndef ACLK_SNOOZE_EN
        push(3643, 1, 32'd1, "snooze_ignored");
        goto(3642);
        pulse_snooze(2'b01);
`endif
        goto(3644);
        AL_ON = 2'b10;

`ifdef ACLK_SNOOZE_EN
        goto(3650);
        AL_ON = 2'b01;
        load_hm(0, 1, 0, 23, 58);
        load_hm(1, 0, 0, 23, 57);
        push(4252, 1, 32'd1,       "ring_2358");
        push(4254, 1, 32'd1,       "ring_2358_hold");
        push(4255, 1, 32'd0,       "snoozed");
        push(7251, 1, 32'd0,       "snoozed_pre_deadline");
        push(7252, 0, tm(0, 3, 0), "at_0003");
        push(7252, 1, 32'd1,       "re_ring_0003");
        push(7256, 1, 32'd0,       "re_ring_stopped");
        goto(4254);
        pulse_snooze(2'b01);
        goto(7255);
        pulse_stop(2'b01);
        goto(7260);
        load_hm(0, 1, 0, 0, 4);
        push(7852,  1, 32'd1,       "ring_0004");
        push(7855,  1, 32'd0,       "snoozed2");
        push(10852, 0, tm(0, 9, 0), "at_0009");
        push(10852, 1, 32'd0,       "no_re_ring_after_stop");
        goto(7854);
        pulse_snooze(2'b01);
        goto(7860);
        pulse_stop(2'b01);
        goto(10855);
`else
        goto(3650);
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
